wb_port_arbiter: RTL
====================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single 16-bit register-file write port between two requesters:
//  A = ALU result, B = memory load data. Round-robin arbitration with an optional
//  per-requester lock for multi-beat sequences, bounded by LOCK_MAX beats.
//  Drives the select of the write-back 2:1 data mux and registers the winning
//  beat (data, address, enable) into the register-file write stage.
// PARAMETERS
//  ADDR_WIDTH  4  register-file address width
//  LOCK_MAX    8  max consecutive beats one locked owner may hold the port (>=2)
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  a_valid      in   1   A has a beat to write
//  a_lock       in   1   A requests to keep ownership after this beat
//  a_addr       in   AW  A destination register
//  a_data       in   16  A write data
//  a_ready      out  1   A beat accepted this cycle (valid & ready)
//  b_valid/b_lock/b_addr/b_data/b_ready   same as A, for requester B
//  wr_stall     in   1   register file cannot take a write this cycle
//  mux_sel      out  1   combinational grant: 1 = A, 0 = B (data mux enable)
//  wr_en        out  1   registered write enable to register file
//  wr_addr      out  AW  registered write address
//  wr_data      out  16  registered write data
// BEHAVIOUR
//  - Reset (async, active-high): state=IDLE, prio=A, lock_cnt=0, wr_en=0,
//    wr_addr=0, wr_data=0. Outputs hold reset values until first clk after release.
//  - wr_stall=1: a_ready=b_ready=0; wr_en/wr_addr/wr_data hold; state, prio,
//    lock_cnt hold. wr_stall=0: output register loads every cycle.
//  - Grant (combinational, only when wr_stall=0):
//    IDLE: one valid -> that one; both valid -> prio side; none -> no grant.
//    LOCK_A: only A grantable; b_ready=0. LOCK_B: mirror.
//  - x_ready = grant_x & x_valid. mux_sel=1 iff A granted, else 0 (idle -> 0).
//  - Latency 1: accepted beat appears on wr_en/wr_addr/wr_data next edge;
//    cycle with no accept (and no stall) loads wr_en=0, addr/data hold.
//  - prio: after an accepted beat that leaves state IDLE-bound (see below),
//    prio points to the other requester. Unchanged when no beat accepted.
//  - FSM (IDLE, LOCK_A, LOCK_B), transitions on accepted beat of owner X:
//    IDLE  & x_lock=1 -> LOCK_X, lock_cnt=1; x_lock=0 -> IDLE, prio flips.
//    LOCK_X & x_lock=1 & lock_cnt<LOCK_MAX-1 -> stay, lock_cnt+1.
//    LOCK_X & (x_lock=0 | lock_cnt==LOCK_MAX-1) -> IDLE, lock_cnt=0, prio=other.
//    LOCK_X with no accept (x_valid=0): stay, lock_cnt holds (no timeout).
//  - Forced release at LOCK_MAX applies even if other side is idle; owner
//    re-wins in IDLE if other not valid.
//  - Both valid in IDLE, same cycle: exactly one ready; never both.
//  - Reset mid-lock: immediate return to IDLE, any unregistered beat dropped.
// STRUCTURE
//  - Shared package/header: state encodings (ST_IDLE=2'd0, ST_LOCK_A=2'd1,
//    ST_LOCK_B=2'd2), SEL_A=1'b1, SEL_B=1'b0, DATA_WIDTH=16.
//  - Data path: instantiate existing twoInputMux (enable=mux_sel,
//    inputA=a_data, inputB=b_data); address select inline.
//  - Sub-module rr_grant2: combinational 2-way round-robin pick (valids, prio,
//    state -> grant_a, grant_b). Counter, FSM and output regs in top.
// TESTING
//  1 Reset: assert reset mid-run with a_valid=1 -> wr_en=0, wr_addr=0,
//    wr_data=0 immediately; after release first grant goes to A when both valid.
//  2 Alternation: a/b valid every cycle, lock=0, A=16'h1111 addr 1, B=16'h2222
//    addr 2 -> wr_data sequence 1111,2222,1111,... one cycle after each ready.
//  3 Lock: a_lock=1 for 3 beats then 0, b_valid=1 throughout -> 4 A beats
//    consecutive, b_ready=0 during them, then B beat.
//  4 LOCK_MAX: a_lock held high, b_valid=1, LOCK_MAX=8 -> exactly 8 A beats,
//    then B granted on the following cycle.
//  5 Stall: wr_stall=1 for 3 cycles with A=16'hBEEF registered -> wr_en/data
//    held at 1/BEEF, a_ready=b_ready=0, FSM unchanged; resumes after release.
//  6 Single requester: only b_valid, 5 beats -> b_ready every cycle, mux_sel=0.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the write-back port arbiter.
//   state_t    : arbiter FSM encoding (IDLE / LOCK_A / LOCK_B)
//   SEL_A/B    : write-back mux select / priority encoding (1 = A, 0 = B)
//   DATA_WIDTH : register-file write data width
`timescale 1ns/1ps
package wb_port_arbiter_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/twoInputMux.sv
// Generic 2:1 data mux used on the write-back path.
//   enable     : 1 selects inputA, 0 selects inputB
//   inputA/B   : candidate data words
//   outputData : selected word
`timescale 1ns/1ps
module twoInputMux #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             enable,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic [WIDTH-1:0] outputData
);

  assign outputData = enable ? inputA : inputB;

endmodule

// File: rtl/wb_port_arbiter_grant.sv
// Combinational 2-way round-robin pick for the write-back port.
//   i_a_valid/i_b_valid : requester valids
//   i_prio              : side that wins a tie in IDLE (SEL_A / SEL_B)
//   i_state             : arbiter state; a lock restricts the grant to its owner
//   o_grant_a/o_grant_b : one-hot (or zero) grant
`timescale 1ns/1ps
module rr_grant2
  import wb_port_arbiter_pkg::*;
(
  input  logic   i_a_valid,
  input  logic   i_b_valid,
  input  logic   i_prio,
  input  state_t i_state,
  output logic   o_grant_a,
  output logic   o_grant_b
);

  always_comb begin
    o_grant_a = 1'b0;
    o_grant_b = 1'b0;
    case (i_state)
      ST_IDLE: begin
        if (i_a_valid && i_b_valid) begin
          o_grant_a = (i_prio == SEL_A);
          o_grant_b = (i_prio == SEL_B);
        end else begin
          o_grant_a = i_a_valid;
          o_grant_b = i_b_valid;
        end
      end
      ST_LOCK_A: o_grant_a = i_a_valid;
      ST_LOCK_B: o_grant_b = i_b_valid;
      default: begin
        o_grant_a = 1'b0;
        o_grant_b = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between A (ALU) and B (load).
//   clk, reset                      : clock, async active-high reset
//   a_valid/a_lock/a_addr/a_data    : requester A beat; a_ready = beat accepted
//   b_valid/b_lock/b_addr/b_data    : requester B beat; b_ready = beat accepted
//   wr_stall                        : register file cannot accept a write
//   mux_sel                         : combinational data-mux select (1 = A)
//   wr_en/wr_addr/wr_data           : registered write to the register file
`timescale 1ns/1ps
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned LOCK_MAX   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  input  logic                  a_lock,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic                  b_lock,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  input  logic                  wr_stall,
  output logic                  mux_sel,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX);

  state_t                r_state;
  logic                  r_prio;
  logic [CNT_W-1:0]      r_lock_cnt;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;

  state_t                w_state_nxt;
  logic                  w_prio_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_wr_en_nxt;
  logic [ADDR_WIDTH-1:0] w_wr_addr_nxt;
  logic [DATA_WIDTH-1:0] w_wr_data_nxt;

  logic                  w_grant_a_raw;
  logic                  w_grant_b_raw;
  logic                  w_grant_a;
  logic                  w_grant_b;
  logic                  w_accept;
  logic                  w_last_beat;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;

  rr_grant2 u_grant (
    .i_a_valid (a_valid),
    .i_b_valid (b_valid),
    .i_prio    (r_prio),
    .i_state   (r_state),
    .o_grant_a (w_grant_a_raw),
    .o_grant_b (w_grant_b_raw)
  );

  // A stalled register file blocks every grant, so nothing is accepted.
  assign w_grant_a = w_grant_a_raw & ~wr_stall;
  assign w_grant_b = w_grant_b_raw & ~wr_stall;
  assign a_ready   = w_grant_a & a_valid;
  assign b_ready   = w_grant_b & b_valid;
  assign mux_sel   = w_grant_a ? SEL_A : SEL_B;
  assign w_accept  = a_ready | b_ready;

  twoInputMux #(.WIDTH(DATA_WIDTH)) u_data_mux (
    .enable     (mux_sel),
    .inputA     (a_data),
    .inputB     (b_data),
    .outputData (w_sel_data)
  );

  assign w_sel_addr  = (mux_sel == SEL_A) ? a_addr : b_addr;
  assign w_last_beat = (r_lock_cnt == CNT_W'(LOCK_MAX - 1));

  // State, priority, lock counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_prio     <= SEL_A;
      r_lock_cnt <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_prio     <= w_prio_nxt;
      r_lock_cnt <= w_cnt_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
    end
  end

  // Next-state: lock entry/extension/release and write-stage load.
  always_comb begin
    w_state_nxt   = r_state;
    w_prio_nxt    = r_prio;
    w_cnt_nxt     = r_lock_cnt;
    w_wr_en_nxt   = wr_stall ? r_wr_en : w_accept;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;

    if (w_accept) begin
      w_wr_addr_nxt = w_sel_addr;
      w_wr_data_nxt = w_sel_data;
    end

    case (r_state)
      ST_IDLE: begin
        if (a_ready) begin
          if (a_lock) begin
            w_state_nxt = ST_LOCK_A;
            w_cnt_nxt   = CNT_W'(1);
          end else begin
            w_prio_nxt  = SEL_B;
          end
        end else if (b_ready) begin
          if (b_lock) begin
            w_state_nxt = ST_LOCK_B;
            w_cnt_nxt   = CNT_W'(1);
          end else begin
            w_prio_nxt  = SEL_A;
          end
        end
      end
      ST_LOCK_A: begin
        if (a_ready) begin
          if (a_lock && !w_last_beat) begin
            w_cnt_nxt   = r_lock_cnt + CNT_W'(1);
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_prio_nxt  = SEL_B;
          end
        end
      end
      ST_LOCK_B: begin
        if (b_ready) begin
          if (b_lock && !w_last_beat) begin
            w_cnt_nxt   = r_lock_cnt + CNT_W'(1);
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_prio_nxt  = SEL_A;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule
